// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared widths and FSM states for the main memory model.
package mem_if_pkg;
  localparam int LINE_W = 128;
  localparam int MEM_ADDR_W = 28;
  localparam int WORD_W = 32;
  localparam int CNT_W = 8;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
endpackage

// File: rtl/mem_line_array.sv
// mem_line_array: line storage with sync write, registered read and reset pattern load.
module mem_line_array
  import mem_if_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);
  logic [LINE_W-1:0] mem_q [DEPTH];
  logic [LINE_W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        for (int k = 0; k < LINE_W / WORD_W; k++)
          mem_q[i][WORD_W*k +: WORD_W] <= WORD_W'(4 * i + k);
      rdata_q <= '0;
    end else begin
      if (we_i) mem_q[idx_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[idx_i];
    end
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/main_memory_model.sv
// main_memory_model: fixed-latency line memory responder for the L2 cache.
module main_memory_model
  import mem_if_pkg::*;
#(
  parameter int LATENCY = 8,
  parameter int DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0]     mem_wdata,
  output logic [LINE_W-1:0]     mem_rdata,
  output logic                  mem_ready
);
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic wr_q, wr_d, rd_q, rd_d;
  logic accept, busy, done;
  // upper address bits alias onto the array and are deliberately dropped
  logic [MEM_ADDR_W-1:0] unused_addr;
  assign unused_addr = mem_addr;
  always_comb begin
    accept  = state_q == IDLE && (mem_read || mem_write);
    busy    = state_q == BUSY;
    done    = busy && cnt_q == '0;
    state_d = accept ? BUSY : done ? RESP : busy ? BUSY : IDLE;
    cnt_d   = accept ? CNT_W'(LATENCY - 1) : busy && !done ? cnt_q - 1'b1 : '0;
    idx_d   = accept ? mem_addr[IDX_W-1:0] : idx_q;
    wdata_d = accept ? mem_wdata : wdata_q;
    wr_d    = accept ? mem_write : wr_q;
    rd_d    = accept ? mem_read && !mem_write : rd_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end
  assign mem_ready = state_q == RESP;
  mem_line_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
    .clk     (clk),
    .reset   (reset),
    .we_i    (done && wr_q),
    .re_i    (done && rd_q),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );
endmodule

// File: tb/tb_main_memory_model.sv
// tb_main_memory_model: scoreboard bench for LATENCY=8 and LATENCY=1 instances.
module tb_main_memory_model;
  logic clk = 1'b0, reset = 1'b1;
  logic rd8 = 0, wr8 = 0, rdy8, rd1 = 0, wr1 = 0, rdy1;
  logic [27:0] addr8 = '0, addr1 = '0;
  logic [127:0] wdata8 = '0, wdata1 = '0, rdata8, rdata1;
  logic [127:0] model [256];
  logic [127:0] q8 [$];
  logic [127:0] q1 [$];
  logic [127:0] last8 = '0;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  main_memory_model #(.LATENCY(8), .DEPTH(256)) dut8 (
    .clk(clk), .reset(reset), .mem_read(rd8), .mem_write(wr8), .mem_addr(addr8),
    .mem_wdata(wdata8), .mem_rdata(rdata8), .mem_ready(rdy8));
  main_memory_model #(.LATENCY(1), .DEPTH(256)) dut1 (
    .clk(clk), .reset(reset), .mem_read(rd1), .mem_write(wr1), .mem_addr(addr1),
    .mem_wdata(wdata1), .mem_rdata(rdata1), .mem_ready(rdy1));
  function automatic logic [127:0] pat(input int i);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[32*k +: 32] = 32'(4 * i + k);
    return r;
  endfunction
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else passed++;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rd8 = 0; wr8 = 0; rd1 = 0; wr1 = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = pat(i);
    last8 = '0;
    q8.delete();
    q1.delete();
  endtask
  task automatic xact8(input logic rd, input logic wr, input logic [27:0] a, input logic [127:0] d);
    int n;
    logic [127:0] e;
    @(negedge clk);
    rd8 = rd; wr8 = wr; addr8 = a; wdata8 = d;
    if (wr) model[a[7:0]] = d;
    else if (rd) q8.push_back(model[a[7:0]]);
    @(posedge clk);
    #1 addr8 = 28'($urandom); wdata8 = {4{$urandom}};
    n = 0;
    do begin @(negedge clk); n++; end while (!rdy8 && n < 300);
    chk("latency8", n, 9);
    if (rdy8 && rd && !wr && q8.size() > 0) begin
      e = q8.pop_front();
      chk("rdata8", rdata8, e);
      last8 = e;
    end else chk("rdata8_hold", rdata8, last8);
    rd8 = 0; wr8 = 0;
    @(negedge clk);
    chk("pulse8_single", rdy8, 0);
  endtask
  initial begin
    logic seen;
    logic [27:0] base [6];
    base = '{28'h5, 28'h42, 28'hFF, 28'h1234_501, 28'h0, 28'h77};
    for (int i = 0; i < 256; i++) model[i] = pat(i);
    repeat (2) @(negedge clk);
    chk("rst_ready8", rdy8, 0);
    chk("rst_rdata8", rdata8, 0);
    chk("rst_ready1", rdy1, 0);
    reset = 1'b0;
    xact8(1, 0, 28'h0000005, '0);
    chk("tp_read5", rdata8, 128'h00000017_00000016_00000015_00000014);
    xact8(0, 1, 28'h10, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);
    xact8(1, 0, 28'h10, '0);
    xact8(0, 1, 28'h010, 128'h55AA55AA_0F0F0F0F_12345678_9ABCDEF0);
    xact8(1, 0, 28'h110, '0);
    xact8(1, 1, 28'h3, 128'h1);
    xact8(1, 0, 28'h3, '0);
    xact8(1, 0, 28'hFFFFFFF, '0);
    @(negedge clk);
    wr8 = 1; addr8 = 28'h20; wdata8 = 128'hBAD0BAD0;
    @(posedge clk);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wr8 = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = pat(i);
    last8 = '0;
    chk("midrst_rdata", rdata8, 0);
    seen = 0;
    repeat (12) begin @(negedge clk); seen |= rdy8; end
    chk("midrst_no_pulse", seen, 0);
    xact8(1, 0, 28'h20, '0);
    chk("tp_read20", rdata8, 128'h00000083_00000082_00000081_00000080);
    do_reset();
    rd1 = 1;
    addr1 = base[0];
    q1.push_back(pat(int'(base[0][7:0])));
    for (int j = 0; j < 6; j++) begin
      @(posedge clk);
      #1 addr1 = 28'($urandom);
      @(negedge clk);
      chk("l1_busy", rdy1, 0);
      @(negedge clk);
      chk("l1_ready", rdy1, 1);
      if (q1.size() > 0) chk("l1_rdata", rdata1, q1.pop_front());
      @(negedge clk);
      chk("l1_idle", rdy1, 0);
      if (j < 5) begin
        addr1 = base[j+1];
        q1.push_back(pat(int'(base[j+1][7:0])));
      end else rd1 = 0;
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
